// File: rtl/bus_arbiter_4.sv
// Four-way round-robin bus arbiter with a bounded hold time and a one-cycle
// turnaround gap between owners. All outputs are registered.
module bus_arbiter_4 #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       busy,
  output logic       preempt
);
  localparam int HW = $clog2(MAX_HOLD + 1);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t        state;
  logic [1:0]    ptr;
  logic [HW-1:0] hold_cnt;
  logic [1:0]    win;
  logic          any_req, others, at_max, release_now;

  // Scan from the farthest candidate back to ptr so the nearest requester wins.
  always_comb begin
    win = ptr;
    for (int k = 3; k >= 0; k--)
      if (req[ptr + 2'(k)]) win = ptr + 2'(k);
  end

  assign any_req     = |req;
  assign others      = |(req & ~(4'b0001 << sel));
  assign at_max      = (hold_cnt == HW'(MAX_HOLD));
  assign release_now = !req[sel] || (at_max && others);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= 4'b0000;
      sel      <= 2'd0;
      busy     <= 1'b0;
      preempt  <= 1'b0;
      ptr      <= 2'd0;
      hold_cnt <= '0;
    end else begin
      preempt <= 1'b0;
      case (state)
        IDLE, GAP: begin
          if (any_req) begin
            state    <= GRANT;
            gnt      <= 4'b0001 << win;
            sel      <= win;
            busy     <= 1'b1;
            hold_cnt <= HW'(1);
          end else begin
            state <= IDLE;
            gnt   <= 4'b0000;
            busy  <= 1'b0;
          end
        end
        GRANT: begin
          if (release_now) begin
            // A still-asserted request here means the owner was forced off.
            state    <= GAP;
            gnt      <= 4'b0000;
            busy     <= 1'b0;
            preempt  <= req[sel];
            ptr      <= sel + 2'd1;
            hold_cnt <= '0;
          end else if (!at_max) begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= 4'b0000;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_bus_arbiter_4.sv
// Bench for bus_arbiter_4: directed scenarios plus randomized requests
// compared against an owner/pointer reference model.
module tb_bus_arbiter_4;
  localparam int MAX_HOLD = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy, preempt;

  int checks = 0;
  int errors = 0;

  bus_arbiter_4 #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst(rst), .req(req),
    .gnt(gnt), .sel(sel), .busy(busy), .preempt(preempt)
  );

  always #5 clk = ~clk;

  // Reference model: who owns the bus, for how long, and where the search starts.
  typedef struct {
    int owner;
    int ptr;
    int held;
    int sel;
    bit pre;
  } mstate_t;

  mstate_t m = '{-1, 0, 0, 0, 1'b0};

  function automatic mstate_t model_next(mstate_t c, logic [3:0] r, logic rs);
    mstate_t n = c;
    bit found = 0;
    n.pre = 1'b0;
    if (rs) begin
      n.owner = -1; n.ptr = 0; n.held = 0; n.sel = 0;
      return n;
    end
    if (c.owner >= 0) begin
      if (!r[c.owner] || (c.held >= MAX_HOLD && (r & ~(4'b0001 << c.owner)) != 4'b0)) begin
        n.pre   = r[c.owner];
        n.ptr   = (c.owner + 1) % 4;
        n.owner = -1;
      end else begin
        n.held = c.held + 1;
      end
    end else if (r != 4'b0) begin
      for (int k = 0; k < 4; k++) begin
        if (!found && r[(c.ptr + k) % 4]) begin
          found   = 1;
          n.owner = (c.ptr + k) % 4;
        end
      end
      n.sel  = n.owner;
      n.held = 1;
    end
    return n;
  endfunction

  always @(posedge clk) m <= model_next(m, req, rst);

  // Invariant watcher, independent of the model.
  bit         chk_on = 0;
  logic [3:0] req_edge = 4'b0;
  logic [3:0] prev_gnt = 4'b0;
  int         prev_run = 0;

  always @(posedge clk) req_edge <= req;

  always @(negedge clk) begin
    if (chk_on) begin
      checks++;
      if ($countones(gnt) > 1) begin
        errors++;
        $display("FAIL onehot: gnt=%b required at most one bit set", gnt);
      end
      checks++;
      if (prev_gnt != 4'b0 && gnt != 4'b0 && gnt != prev_gnt) begin
        errors++;
        $display("FAIL gnt_handover: gnt %b -> %b required a zero gap", prev_gnt, gnt);
      end
      if (preempt) begin
        checks++;
        if (!(prev_gnt != 4'b0 && prev_run >= MAX_HOLD && (req_edge & prev_gnt) != 4'b0 &&
              (req_edge & ~prev_gnt) != 4'b0)) begin
          errors++;
          $display("FAIL preempt_cause: preempt=1 with run=%0d req=%b prev_gnt=%b, required run>=%0d and competitors",
                   prev_run, req_edge, prev_gnt, MAX_HOLD);
        end
      end
    end
    prev_run <= (gnt != 4'b0 && gnt == prev_gnt) ? prev_run + 1 : ((gnt != 4'b0) ? 1 : 0);
    prev_gnt <= gnt;
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req = 4'b0000;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0000 || sel !== 2'd0 || busy !== 1'b0 || preempt !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: gnt=%b sel=%0d busy=%b preempt=%b, required 0000/0/0/0",
               gnt, sel, busy, preempt);
    end
    chk_on = 1;
  endtask

  task automatic test_lone();
    do_reset();
    req = 4'b0100;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0100 || sel !== 2'd2 || busy !== 1'b1) begin
      errors++;
      $display("FAIL lone_grant: gnt=%b sel=%0d busy=%b, required 0100/2/1", gnt, sel, busy);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (gnt !== 4'b0100 || preempt !== 1'b0) begin
        errors++;
        $display("FAIL lone_hold cycle %0d: gnt=%b preempt=%b, required 0100/0", i, gnt, preempt);
      end
    end
    req = 4'b0000;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0000 || busy !== 1'b0 || sel !== 2'd2) begin
      errors++;
      $display("FAIL lone_release: gnt=%b busy=%b sel=%0d, required 0000/0/2", gnt, busy, sel);
    end
  endtask

  task automatic test_all_rr();
    int order[5] = '{0, 1, 2, 3, 0};
    do_reset();
    req = 4'b1111;
    foreach (order[j]) begin
      for (int c = 0; c < MAX_HOLD; c++) begin
        @(negedge clk);
        checks++;
        if (gnt !== (4'b0001 << order[j]) || preempt !== 1'b0 || sel !== 2'(order[j])) begin
          errors++;
          $display("FAIL rr_hold owner %0d cycle %0d: gnt=%b sel=%0d preempt=%b, required %b/%0d/0",
                   order[j], c, gnt, sel, preempt, 4'b0001 << order[j], order[j]);
        end
      end
      @(negedge clk);
      checks++;
      if (gnt !== 4'b0000 || preempt !== 1'b1) begin
        errors++;
        $display("FAIL rr_preempt owner %0d: gnt=%b preempt=%b, required 0000/1", order[j], gnt, preempt);
      end
    end
    req = 4'b0000;
  endtask

  task automatic test_wrap();
    do_reset();
    req = 4'b1000;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b1000 || sel !== 2'd3) begin
      errors++;
      $display("FAIL wrap_grant3: gnt=%b sel=%0d, required 1000/3", gnt, sel);
    end
    req = 4'b1001;
    repeat (2) @(negedge clk);
    checks++;
    if (gnt !== 4'b1000) begin
      errors++;
      $display("FAIL wrap_hold3: gnt=%b, required 1000", gnt);
    end
    req = 4'b0001;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0000 || sel !== 2'd3 || preempt !== 1'b0) begin
      errors++;
      $display("FAIL wrap_gap: gnt=%b sel=%0d preempt=%b, required 0000/3/0", gnt, sel, preempt);
    end
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0001 || sel !== 2'd0) begin
      errors++;
      $display("FAIL wrap_grant0: gnt=%b sel=%0d, required 0001/0", gnt, sel);
    end
    req = 4'b0000;
  endtask

  task automatic test_simul();
    do_reset();
    req = 4'b0011;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0001) begin
      errors++;
      $display("FAIL simul_first: gnt=%b, required 0001", gnt);
    end
    req = 4'b0010;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0000) begin
      errors++;
      $display("FAIL simul_gap: gnt=%b, required 0000", gnt);
    end
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0010 || sel !== 2'd1) begin
      errors++;
      $display("FAIL simul_second: gnt=%b sel=%0d, required 0010/1", gnt, sel);
    end
    req = 4'b0000;
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 4'b0100;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0100) begin
      errors++;
      $display("FAIL rstmid_grant: gnt=%b, required 0100", gnt);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0000 || sel !== 2'd0 || busy !== 1'b0 || preempt !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_drop: gnt=%b sel=%0d busy=%b preempt=%b, required 0000/0/0/0",
               gnt, sel, busy, preempt);
    end
    rst = 1'b0;
    req = 4'b0110;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0010 || sel !== 2'd1) begin
      errors++;
      $display("FAIL rstmid_resume: gnt=%b sel=%0d, required 0010/1", gnt, sel);
    end
    req = 4'b0000;
  endtask

  task automatic test_random();
    logic [3:0] eg;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      eg = (m.owner >= 0) ? (4'b0001 << m.owner) : 4'b0000;
      checks++;
      if (gnt !== eg || sel !== 2'(m.sel) || busy !== (m.owner >= 0) || preempt !== m.pre) begin
        errors++;
        $display("FAIL random cycle %0d: gnt=%b sel=%0d busy=%b preempt=%b, required %b/%0d/%b/%b",
                 i, gnt, sel, busy, preempt, eg, m.sel, m.owner >= 0, m.pre);
      end
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 9) == 0) req[b] = ~req[b];
      rst = ($urandom_range(0, 149) == 0);
    end
    rst = 1'b0;
    req = 4'b0000;
  endtask

  initial begin
    rst = 1'b1;
    req = 4'b0000;
    test_reset();
    test_lone();
    test_all_rr();
    test_wrap();
    test_simul();
    test_reset_mid();
    test_random();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bus_arbiter_4.md
BUS_ARBITER_4 -- requirements
Module: bus_arbiter_4

Interface
REQ-001 The module SHALL have parameter MAX_HOLD, default 8, giving the maximum consecutive grant cycles for one owner while others wait; legal range is 1..255.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 req  input  4  per-requester request; bit i SHALL be held high by requester i for as long as it needs the shared port.
REQ-005 gnt  output  4  one-hot grant to the current owner; all-zero when nobody owns the port.
REQ-006 sel  output  2  index of the current or most recent owner; drives the select input of the shared 4:1 data mux.
REQ-007 busy  output  1  high while in the GRANT state.
REQ-008 preempt  output  1  one-cycle pulse when an owner is forcibly released at MAX_HOLD.
REQ-009 All outputs SHALL be registered.

Function
REQ-010 The FSM SHALL have exactly three states: IDLE, GRANT and GAP.
REQ-011 Round-robin pointer ptr[1:0]: the search order SHALL be ptr, ptr+1, ptr+2, ptr+3 (mod 4), and the winner SHALL be the first index in that order with req set.
REQ-012 IDLE: if req != 0, the FSM SHALL move next cycle to GRANT with gnt=onehot(winner), sel=winner and hold_cnt=1; otherwise it SHALL stay in IDLE with gnt=0.
REQ-013 GRANT, owner release: if req[sel]=0, the FSM SHALL move next cycle to GAP with gnt=0.
REQ-014 GRANT, forced release: if req[sel]=1, hold_cnt=MAX_HOLD and any other req bit is set, the FSM SHALL move next cycle to GAP with gnt=0 and preempt=1 for that one cycle.
REQ-015 GRANT, continue: in all other cases the FSM SHALL stay in GRANT, and hold_cnt SHALL increment, saturating at MAX_HOLD.
REQ-016 A lone requester SHALL keep its grant indefinitely, with hold_cnt saturated.
REQ-017 On every exit from GRANT, ptr SHALL become sel+1 (mod 4), wrapping from 3 to 0.
REQ-018 GAP: gnt SHALL be 0 for exactly one cycle (bus turnaround); the FSM SHALL then go to GRANT via REQ-011/012 using the updated ptr if req != 0, and to IDLE otherwise.
REQ-019 gnt SHALL never have more than one bit set, and SHALL never change directly from one nonzero value to another.
REQ-020 sel SHALL change only on entry to GRANT, and SHALL hold its value through GAP and IDLE.
REQ-021 Latency: from IDLE, a request seen at edge N SHALL produce gnt at edge N+1.
REQ-022 Latency: after an owner drops req at edge N, the next waiting requester SHALL be granted at edge N+2.
REQ-023 A requester dropping req in the same cycle it is granted SHALL be treated as a release at the next evaluation; it receives one cycle of grant.
REQ-024 hold_cnt width SHALL be clog2(MAX_HOLD+1) bits; it SHALL never wrap.
REQ-025 preempt SHALL be 0 in every cycle other than the GRANT->GAP transition caused by REQ-014.

Reset
REQ-026 When rst=1 at an edge: state=IDLE, gnt=0, sel=0, busy=0, preempt=0, ptr=0, hold_cnt=0, overriding all other conditions.
REQ-027 Reset asserted mid-GRANT SHALL drop gnt to 0 at that same edge, with no GAP cycle.
REQ-028 After rst deasserts, arbitration SHALL resume per REQ-012 on the first edge with rst=0.

Verification
REQ-029 Reset, then req=4'b0100 held -> gnt=0100, sel=2, busy=1 one cycle later; grant held for 20 cycles; preempt stays 0.
REQ-030 req=4'b1111 held, MAX_HOLD=8 -> grant order 0,1,2,3,0; each owner has 8 gnt cycles, then a preempt pulse, then 1 GAP cycle with gnt=0.
REQ-031 Owner 3 releases while req[0] is pending -> ptr wraps to 0; gnt=0001 two edges after the release; sel holds 3 during GAP.
REQ-032 req=4'b0011 arrive simultaneously from reset -> gnt=0001 first; after release, gnt=0010; gnt is never 0011.
REQ-033 rst pulsed while gnt=0100 -> gnt=0, sel=0 at the reset edge; after reset with req=0110 -> gnt=0010 (ptr=0).
REQ-034 Every test: assertions check that gnt is one-hot or zero, that there is no nonzero-to-nonzero gnt change, and that preempt occurs only at hold_cnt=MAX_HOLD with competing requests.
